seg_scan_mux: RTL and testbench



---
 rtl/seg_disp_pkg.sv | 27 ++
 rtl/seg_scan_timer.sv | 79 +++++++
 rtl/seg_scan_mux.sv | 121 ++++++++++++
 tb/tb_seg_scan_mux.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
// Shared constants and types for the 8-digit multiplexed 7-segment display.
//   N_DIGITS   : number of physical digits (player 0 on idx 0..3, player 1 on 4..7)
//   DP_IDX_P0/1: digit slots that light the decimal point (minutes/seconds split)
//   SEG_W      : segment bus width, bit0 = a .. bit6 = g
//   seg_code_t : one digit's segment code, 1 = segment lit
//   SEG_BLANK  : code with every segment off
// -----------------------------------------------------------------------------
package seg_disp_pkg;

    localparam int N_DIGITS  = 8;
    localparam int IDX_W     = 3;
    localparam int DP_IDX_P0 = 2;
    localparam int DP_IDX_P1 = 6;
    localparam int SEG_W     = 7;

    typedef logic [SEG_W-1:0] seg_code_t;

    localparam seg_code_t SEG_BLANK = '0;

    // Decimal point sits to the left of the tens-of-seconds digit of each player.
    function automatic logic dp_at(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DP_IDX_P0)) || (idx == IDX_W'(DP_IDX_P1));
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// -----------------------------------------------------------------------------
// seg_scan_timer
// Scan sequencer for the multiplexed display. Counts cycles within a digit slot
// (cnt), the digit slot itself (idx), whole 8-digit frames (frm) and the blink
// phase (ph). Everything advances only while CE is high.
// Ports:
//   CLK      in  system clock
//   CLR      in  synchronous active-high reset, overrides CE
//   CE       in  scan enable; low freezes all counters
//   idx_o    out current digit slot 0..7
//   drive_o  out 1 once the slot's leading blank cycles have elapsed
//   ph_o     out blink phase; 1 = blinking digits are hidden
// -----------------------------------------------------------------------------
module seg_scan_timer
    import seg_disp_pkg::*;
#(
    parameter int DIV          = 4,
    parameter int BLANK        = 1,
    parameter int BLINK_FRAMES = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    output logic [IDX_W-1:0] idx_o,
    output logic             drive_o,
    output logic             ph_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             ph_q,  ph_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        frm_d = frm_q;
        ph_d  = ph_q;
        if (CE) begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                cnt_d = '0;
                idx_d = idx_q + 1'b1;   // 7 -> 0 wraps naturally in 3 bits
                if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                    // End of a full frame: advance the blink frame counter.
                    if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                        frm_d = '0;
                        ph_d  = ~ph_q;
                    end else begin
                        frm_d = frm_q + 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt_q <= '0;
            idx_q <= '0;
            frm_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            frm_q <= frm_d;
            ph_q  <= ph_d;
        end
    end

    assign idx_o   = idx_q;
    assign drive_o = (cnt_q >= CNT_W'(BLANK));
    assign ph_o    = ph_q;

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexes the chess clock's eight digit codes onto one 8-digit
// display with a shared segment bus. Each slot starts with BLANK dark cycles
// to stop ghosting, the decimal point is lit on slots 2 and 6, and each
// player's digits can blink (hidden while the blink phase is 1).
// Ports:
//   CLK, CLR        clock and synchronous active-high reset
//   CE              scan enable; low freezes the scan and darkens the display
//   seg0_0..seg0_3  player-0 digit codes (seg0_0 = units of seconds)
//   seg1_0..seg1_3  player-1 digit codes
//   BLINK0, BLINK1  per-player blink request, sampled every cycle
//   AN              digit anodes, AN[i] drives digit i
//   SEG, DP         shared segment bus and decimal point
// All outputs are registered (one cycle after the state/inputs they show) and
// carry the pin polarity selected by ACTIVE_LOW.
// -----------------------------------------------------------------------------
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int DIV          = 4,
    parameter int BLANK        = 1,
    parameter int BLINK_FRAMES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CE,
    input  seg_code_t           seg0_0,
    input  seg_code_t           seg0_1,
    input  seg_code_t           seg0_2,
    input  seg_code_t           seg0_3,
    input  seg_code_t           seg1_0,
    input  seg_code_t           seg1_1,
    input  seg_code_t           seg1_2,
    input  seg_code_t           seg1_3,
    input  logic                BLINK0,
    input  logic                BLINK1,
    output logic [N_DIGITS-1:0] AN,
    output seg_code_t           SEG,
    output logic                DP
);

    // Pin-level value of an inactive output bit.
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [IDX_W-1:0]    idx;
    logic                drive;
    logic                ph;

    logic                blink_sel;
    logic                show;
    seg_code_t           code_sel;
    logic [N_DIGITS-1:0] an_d, an_q;
    seg_code_t           seg_d, seg_q;
    logic                dp_d, dp_q;

    seg_scan_timer #(
        .DIV          (DIV),
        .BLANK        (BLANK),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .CLK     (CLK),
        .CLR     (CLR),
        .CE      (CE),
        .idx_o   (idx),
        .drive_o (drive),
        .ph_o    (ph)
    );

    always_comb begin
        code_sel = SEG_BLANK;
        case (idx)
            3'd0: code_sel = seg0_0;
            3'd1: code_sel = seg0_1;
            3'd2: code_sel = seg0_2;
            3'd3: code_sel = seg0_3;
            3'd4: code_sel = seg1_0;
            3'd5: code_sel = seg1_1;
            3'd6: code_sel = seg1_2;
            3'd7: code_sel = seg1_3;
            default: code_sel = SEG_BLANK;
        endcase
    end

    // idx[2] splits player 0 (0..3) from player 1 (4..7).
    assign blink_sel = idx[2] ? BLINK1 : BLINK0;

    // A hidden blink slot behaves exactly like the blank lead-in of a slot.
    assign show = CE && drive && !(ph && blink_sel);

    always_comb begin
        an_d  = '0;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (show) begin
            an_d  = N_DIGITS'(1) << idx;
            seg_d = code_sel;
            dp_d  = dp_at(idx);
        end
    end

    // Polarity is folded in before the register so the pins come straight
    // from flops.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            an_q  <= {N_DIGITS{POL}};
            seg_q <= {SEG_W{POL}};
            dp_q  <= POL;
        end else begin
            an_q  <= an_d  ^ {N_DIGITS{POL}};
            seg_q <= seg_d ^ {SEG_W{POL}};
            dp_q  <= dp_d  ^ POL;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
// Two instances share all inputs: u_hi with high-active pins, u_lo with
// low-active pins. A reference model derives the expected display from the
// number of enabled cycles since reset using plain division/modulo, and
// pushes one expected {AN,SEG,DP} per clock edge into exp_q.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

    localparam int DIV = 4;
    localparam int BLANK = 1;
    localparam int BF = 2;
    localparam int FRAME = 8 * DIV;

    // ---------------- clock / reset ----------------
    logic clk;
    logic clr;
    logic ce;
    logic blink0;
    logic blink1;
    logic [6:0] code [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] an_h, an_l;
    logic [6:0] seg_h, seg_l;
    logic       dp_h, dp_l;

    seg_scan_mux #(.DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) u_hi (
        .CLK(clk), .CLR(clr), .CE(ce),
        .seg0_0(code[0]), .seg0_1(code[1]), .seg0_2(code[2]), .seg0_3(code[3]),
        .seg1_0(code[4]), .seg1_1(code[5]), .seg1_2(code[6]), .seg1_3(code[7]),
        .BLINK0(blink0), .BLINK1(blink1),
        .AN(an_h), .SEG(seg_h), .DP(dp_h)
    );

    seg_scan_mux #(.DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) u_lo (
        .CLK(clk), .CLR(clr), .CE(ce),
        .seg0_0(code[0]), .seg0_1(code[1]), .seg0_2(code[2]), .seg0_3(code[3]),
        .seg1_0(code[4]), .seg1_1(code[5]), .seg1_2(code[6]), .seg1_3(code[7]),
        .BLINK0(blink0), .BLINK1(blink1),
        .AN(an_l), .SEG(seg_l), .DP(dp_l)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] exp_q[$];
    int          t_en;        // enabled cycles since last reset
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;
    int          m_slot, m_pos, m_ph;
    logic        m_hidden;

    always @(posedge clk) begin
        m_an  = '0;
        m_seg = '0;
        m_dp  = 1'b0;
        if (clr) begin
            t_en = 0;
        end else if (ce) begin
            m_slot   = (t_en / DIV) % 8;
            m_pos    = t_en % DIV;
            m_ph     = (t_en / (FRAME * BF)) % 2;
            m_hidden = (m_ph == 1) && ((m_slot < 4) ? blink0 : blink1);
            if (m_pos >= BLANK && !m_hidden) begin
                m_an  = 8'(1) << m_slot;
                m_seg = code[m_slot];
                m_dp  = (m_slot == 2) || (m_slot == 6);
            end
            t_en = t_en + 1;
        end
        exp_q.push_back({m_an, m_seg, m_dp});
    end

    int errors;
    int checks;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    // At most one digit may ever be driven, on either polarity.
    always @(negedge clk) begin
        assert ($onehot0(an_h) && $onehot0(~an_l));
    end

    // ---------------- driver tasks ----------------
    // Advance one edge, then fetch the model's expectation for that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=0 required>=1 entries");
            e_an = '0; e_seg = '0; e_dp = 1'b0;
        end else begin
            {e_an, e_seg, e_dp} = exp_q.pop_front();
        end
    endtask

    task automatic rand_codes();
        for (int i = 0; i < 8; i++) code[i] = 7'($urandom_range(0, 127));
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ce = 1'b1; blink0 = 1'b0; blink1 = 1'b0;
        rand_codes();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({an_h, seg_h, dp_h} !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hi actual=%h required=0000", {an_h, seg_h, dp_h});
            end
            checks++;
            if ({an_l, seg_l, dp_l} !== 16'hFFFF) begin
                errors++;
                $display("FAIL reset_lo actual=%h required=ffff", {an_l, seg_l, dp_l});
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] lat_tab [6];
        lat_tab = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02};
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (an_h !== lat_tab[i]) begin
                errors++;
                $display("FAIL latency_an edge=%0d actual=%h required=%h", i + 1, an_h, lat_tab[i]);
            end
            checks++;
            if (an_l !== ~lat_tab[i]) begin
                errors++;
                $display("FAIL latency_an_lo edge=%0d actual=%h required=%h", i + 1, an_l, ~lat_tab[i]);
            end
        end
    endtask

    task automatic test_mux_dp();
        rand_codes();
        code[0] = 7'h3F; code[2] = 7'h06; code[6] = 7'h5B;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if ({an_h, seg_h, dp_h} !== {e_an, e_seg, e_dp} ||
                {an_l, seg_l, dp_l} !== ~{e_an, e_seg, e_dp}) begin
                errors++;
                $display("FAIL mux_model edge=%0d actual=%h/%h required=%h", k,
                         {an_h, seg_h, dp_h}, {an_l, seg_l, dp_l}, {e_an, e_seg, e_dp});
            end
            if (k == 2 || k == 10 || k == 26 || k == 34) begin
                logic [15:0] want;
                case (k)
                    2:       want = {8'h01, 7'h3F, 1'b0};
                    10:      want = {8'h04, 7'h06, 1'b1};
                    26:      want = {8'h40, 7'h5B, 1'b1};
                    default: want = {8'h01, 7'h3F, 1'b0};   // after the 7->0 wrap
                endcase
                checks++;
                if ({an_h, seg_h, dp_h} !== want) begin
                    errors++;
                    $display("FAIL mux_fixed edge=%0d actual=%h required=%h", k, {an_h, seg_h, dp_h}, want);
                end
            end
        end
    endtask

    task automatic test_blink();
        rand_codes();
        blink0 = 1'b0; blink1 = 1'b1;
        do_reset();
        for (int k = 1; k <= 6 * FRAME; k++) begin
            tick();
            checks++;
            if ({an_h, seg_h, dp_h} !== {e_an, e_seg, e_dp}) begin
                errors++;
                $display("FAIL blink_model edge=%0d actual=%h required=%h", k,
                         {an_h, seg_h, dp_h}, {e_an, e_seg, e_dp});
            end
            if (((k - 1) / FRAME) inside {2, 3}) begin
                checks++;
                if (an_h[7:4] !== 4'h0) begin
                    errors++;
                    $display("FAIL blink_p1_dark edge=%0d actual=%h required=0", k, an_h[7:4]);
                end
            end
        end
        // Frame 6 is in blink phase 1: both players hidden means a dark frame.
        blink0 = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            checks++;
            if (an_h !== 8'h00 || an_l !== 8'hFF) begin
                errors++;
                $display("FAIL blink_both_dark cyc=%0d actual=%h/%h required=00/ff", k, an_h, an_l);
            end
        end
        blink0 = 1'b0; blink1 = 1'b0;
    endtask

    task automatic test_ce_freeze();
        logic [7:0] res_tab [4];
        res_tab = '{8'h08, 8'h08, 8'h00, 8'h10};
        rand_codes();
        do_reset();
        for (int k = 0; k < 14; k++) tick();   // now at idx3, cnt2
        ce = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({an_h, seg_h, dp_h} !== 16'h0000 || {an_l, seg_l, dp_l} !== 16'hFFFF) begin
                errors++;
                $display("FAIL freeze_dark cyc=%0d actual=%h/%h required=0000/ffff", k,
                         {an_h, seg_h, dp_h}, {an_l, seg_l, dp_l});
            end
        end
        ce = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (an_h !== res_tab[k] || {an_h, seg_h, dp_h} !== {e_an, e_seg, e_dp}) begin
                errors++;
                $display("FAIL freeze_resume cyc=%0d actual=%h required=%h", k,
                         {an_h, seg_h, dp_h}, {res_tab[k], e_seg, e_dp});
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_codes();
        do_reset();
        for (int k = 0; k < 22; k++) tick();   // last edge showed idx5 drive
        checks++;
        if (an_h !== 8'h20) begin
            errors++;
            $display("FAIL mid_pre actual=%h required=20", an_h);
        end
        clr = 1'b1;
        tick();
        checks++;
        if ({an_h, seg_h, dp_h} !== 16'h0000 || {an_l, seg_l, dp_l} !== 16'hFFFF) begin
            errors++;
            $display("FAIL mid_reset actual=%h/%h required=0000/ffff", {an_h, seg_h, dp_h}, {an_l, seg_l, dp_l});
        end
        clr = 1'b0;
        tick();
        checks++;
        if (an_h !== 8'h00) begin
            errors++;
            $display("FAIL mid_restart_e1 actual=%h required=00", an_h);
        end
        tick();
        checks++;
        if (an_h !== 8'h01 || seg_h !== code[0]) begin
            errors++;
            $display("FAIL mid_restart_e2 actual=%h/%h required=01/%h", an_h, seg_h, code[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            tick();
            checks++;
            if ({an_h, seg_h, dp_h} !== {e_an, e_seg, e_dp} ||
                {an_l, seg_l, dp_l} !== ~{e_an, e_seg, e_dp} || !$onehot0(an_h)) begin
                errors++;
                $display("FAIL random_model cyc=%0d actual=%h/%h required=%h", k,
                         {an_h, seg_h, dp_h}, {an_l, seg_l, dp_l}, {e_an, e_seg, e_dp});
            end
            ce     = ($urandom_range(0, 9) != 0);
            clr    = ($urandom_range(0, 299) == 0);
            blink0 = ($urandom_range(0, 2) == 0);
            blink1 = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) code[$urandom_range(0, 7)] = 7'($urandom_range(0, 127));
        end
        clr = 1'b0; ce = 1'b1;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        errors = 0;
        checks = 0;
        t_en   = 0;
        clr    = 1'b1;
        ce     = 1'b1;
        blink0 = 1'b0;
        blink1 = 1'b0;
        for (int i = 0; i < 8; i++) code[i] = '0;
        @(posedge clk);
        #1;
        exp_q.delete();

        test_reset();
        test_latency();
        test_mux_dp();
        test_blink();
        test_ce_freeze();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
